// File: rtl/core_mem_wb.sv
// Memory/writeback stage of the 64-bit MIPS pipeline. It performs one data-memory
// access at a time over a req/ack handshake and drives the writeback triple back to ID.
module core_mem_wb #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [4:0]  ex_W_regnum,
  input  logic        ex_write_enable,
  input  logic [63:0] ex_out,
  input  logic [63:0] ex_B_data,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [1:0]  ex_size,
  input  logic        ex_signed,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic [4:0]  W_regnum,
  output logic [63:0] W_data,
  output logic        write_enable,
  output logic        addr_err_load,
  output logic        addr_err_store,
  output logic        bus_err,
  output logic [63:0] err_addr
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  function automatic logic [7:0] byte_enables(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'd0:    byte_enables = 8'h01 << off;
      2'd1:    byte_enables = 8'h03 << off;
      2'd2:    byte_enables = 8'h0F << off;
      default: byte_enables = 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] replicate(input logic [1:0] size, input logic [63:0] data);
    case (size)
      2'd0:    replicate = {8{data[7:0]}};
      2'd1:    replicate = {4{data[15:0]}};
      2'd2:    replicate = {2{data[31:0]}};
      default: replicate = data;
    endcase
  endfunction

  function automatic logic [63:0] load_extract(input logic [63:0] rdata, input logic [2:0] off,
                                               input logic [1:0] size, input logic sgn);
    logic [63:0] raw;
    raw = rdata >> {off, 3'b000};
    case (size)
      2'd0:    load_extract = {{56{sgn & raw[7]}}, raw[7:0]};
      2'd1:    load_extract = {{48{sgn & raw[15]}}, raw[15:0]};
      2'd2:    load_extract = {{32{sgn & raw[31]}}, raw[31:0]};
      default: load_extract = raw;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic               dmem_req_q, dmem_req_d;
  logic               dmem_we_q, dmem_we_d;
  logic [60:0]        addr_hi_q, addr_hi_d;
  logic [63:0]        dmem_wdata_q, dmem_wdata_d;
  logic [7:0]         dmem_be_q, dmem_be_d;
  logic [4:0]         w_regnum_q, w_regnum_d;
  logic [63:0]        w_data_q, w_data_d;
  logic               write_enable_q, write_enable_d;
  logic               addr_err_load_q, addr_err_load_d;
  logic               addr_err_store_q, addr_err_store_d;
  logic               bus_err_q, bus_err_d;
  logic [63:0]        err_addr_q, err_addr_d;
  logic [4:0]         pend_regnum_q, pend_regnum_d;
  logic               pend_we_q, pend_we_d;
  logic               pend_load_q, pend_load_d;
  logic [1:0]         pend_size_q, pend_size_d;
  logic               pend_signed_q, pend_signed_d;
  logic [2:0]         off_q, off_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

  logic [2:0] off_s;
  logic       is_mem_s;
  logic       misaligned_s;
  logic       timeout_s;
  logic       stall_s;

  assign off_s        = ex_out[2:0];
  assign is_mem_s     = ex_is_load | ex_is_store;
  assign misaligned_s = ((ex_size == 2'd1) & off_s[0]) |
                        ((ex_size == 2'd2) & (off_s[1:0] != 2'd0)) |
                        ((ex_size == 2'd3) & (off_s != 3'd0));
  assign timeout_s    = (wait_cnt_q == CNT_W'(MAX_WAIT));

  // Next-state and next-output logic for the IDLE/WAIT access sequencer
  always_comb begin
    state_d          = state_q;
    dmem_req_d       = dmem_req_q;
    dmem_we_d        = dmem_we_q;
    addr_hi_d        = addr_hi_q;
    dmem_wdata_d     = dmem_wdata_q;
    dmem_be_d        = dmem_be_q;
    w_regnum_d       = w_regnum_q;
    w_data_d         = w_data_q;
    write_enable_d   = 1'b0;
    addr_err_load_d  = 1'b0;
    addr_err_store_d = 1'b0;
    bus_err_d        = 1'b0;
    err_addr_d       = err_addr_q;
    pend_regnum_d    = pend_regnum_q;
    pend_we_d        = pend_we_q;
    pend_load_d      = pend_load_q;
    pend_size_d      = pend_size_q;
    pend_signed_d    = pend_signed_q;
    off_d            = off_q;
    wait_cnt_d       = wait_cnt_q;
    stall_s          = 1'b0;

    case (state_q)
      IDLE: begin
        if (ex_valid && !is_mem_s) begin
          w_regnum_d     = ex_W_regnum;
          w_data_d       = ex_out;
          write_enable_d = ex_write_enable;
        end else if (ex_valid && misaligned_s) begin
          addr_err_load_d  = ex_is_load;
          addr_err_store_d = ~ex_is_load;
          err_addr_d       = ex_out;
        end else if (ex_valid) begin
          // Load wins when both load and store flags are set.
          stall_s       = 1'b1;
          state_d       = WAIT;
          dmem_req_d    = 1'b1;
          dmem_we_d     = ex_is_store & ~ex_is_load;
          addr_hi_d     = ex_out[63:3];
          dmem_wdata_d  = replicate(ex_size, ex_B_data);
          dmem_be_d     = byte_enables(ex_size, off_s);
          pend_regnum_d = ex_W_regnum;
          pend_we_d     = ex_write_enable;
          pend_load_d   = ex_is_load;
          pend_size_d   = ex_size;
          pend_signed_d = ex_signed;
          off_d         = off_s;
          wait_cnt_d    = CNT_W'(1);
        end else begin
          wait_cnt_d = {CNT_W{1'b0}};
        end
      end
      WAIT: begin
        stall_s = 1'b1;
        if (dmem_ack) begin
          state_d    = IDLE;
          dmem_req_d = 1'b0;
          if (pend_load_q) begin
            w_regnum_d     = pend_regnum_q;
            w_data_d       = load_extract(dmem_rdata, off_q, pend_size_q, pend_signed_q);
            write_enable_d = pend_we_q;
          end else begin
            write_enable_d = 1'b0;
          end
        end else if (timeout_s) begin
          state_d    = IDLE;
          dmem_req_d = 1'b0;
          bus_err_d  = 1'b1;
          err_addr_d = {addr_hi_q, off_q};
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        dmem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      dmem_req_q       <= 1'b0;
      dmem_we_q        <= 1'b0;
      addr_hi_q        <= 61'd0;
      dmem_wdata_q     <= 64'd0;
      dmem_be_q        <= 8'd0;
      w_regnum_q       <= 5'd0;
      w_data_q         <= 64'd0;
      write_enable_q   <= 1'b0;
      addr_err_load_q  <= 1'b0;
      addr_err_store_q <= 1'b0;
      bus_err_q        <= 1'b0;
      err_addr_q       <= 64'd0;
      pend_regnum_q    <= 5'd0;
      pend_we_q        <= 1'b0;
      pend_load_q      <= 1'b0;
      pend_size_q      <= 2'd0;
      pend_signed_q    <= 1'b0;
      off_q            <= 3'd0;
      wait_cnt_q       <= {CNT_W{1'b0}};
    end else begin
      state_q          <= state_d;
      dmem_req_q       <= dmem_req_d;
      dmem_we_q        <= dmem_we_d;
      addr_hi_q        <= addr_hi_d;
      dmem_wdata_q     <= dmem_wdata_d;
      dmem_be_q        <= dmem_be_d;
      w_regnum_q       <= w_regnum_d;
      w_data_q         <= w_data_d;
      write_enable_q   <= write_enable_d;
      addr_err_load_q  <= addr_err_load_d;
      addr_err_store_q <= addr_err_store_d;
      bus_err_q        <= bus_err_d;
      err_addr_q       <= err_addr_d;
      pend_regnum_q    <= pend_regnum_d;
      pend_we_q        <= pend_we_d;
      pend_load_q      <= pend_load_d;
      pend_size_q      <= pend_size_d;
      pend_signed_q    <= pend_signed_d;
      off_q            <= off_d;
      wait_cnt_q       <= wait_cnt_d;
    end
  end

  assign stall_out      = stall_s;
  assign dmem_req       = dmem_req_q;
  assign dmem_we        = dmem_we_q;
  assign dmem_addr      = {addr_hi_q, 3'b000};
  assign dmem_wdata     = dmem_wdata_q;
  assign dmem_be        = dmem_be_q;
  assign W_regnum       = w_regnum_q;
  assign W_data         = w_data_q;
  assign write_enable   = write_enable_q;
  assign addr_err_load  = addr_err_load_q;
  assign addr_err_store = addr_err_store_q;
  assign bus_err        = bus_err_q;
  assign err_addr       = err_addr_q;

endmodule
